// File: rtl/adder_rr_sched_pkg.sv
// Shared constants for the round-robin adder scheduler: pointer reset value,
// result-slot state encoding and the clog2 helper used to validate ID_WIDTH.
package adder_rr_sched_pkg;

  localparam int RR_PTR_RESET = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational adder, width-parameterised.
// Zero latency, no flow control; callers zero-extend when they want the carry.
module adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_rr_sched_rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr wins, wrapping.
// Combinational; grant is suppressed (winner still reported) when en is low.
module adder_rr_sched_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic                en,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] win,
  output logic                any_req
);

  always_comb begin
    grant   = '0;
    win     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req[(int'(ptr) + k) % NUM_REQ]) begin
        any_req = 1'b1;
        win     = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      end
    end
    if (any_req && en) grant[win] = 1'b1;
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one adder among NUM_REQ requesters; result is
// registered 1 cycle after grant, and a stalled result holds all req_ready_out low.
module adder_rr_sched
  import adder_rr_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          res_valid_out,
  input  logic                          res_ready_in,
  output logic [DATA_WIDTH-1:0]         res_data_out,
  output logic                          res_carry_out,
  output logic [ID_WIDTH-1:0]           res_id_out,
  output logic                          busy_out
);

  if (ID_WIDTH != clog2(NUM_REQ)) begin : g_bad_id_width
    $error("ID_WIDTH must equal clog2(NUM_REQ)");
  end

  slot_state_t           state;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   win;
  logic                  any_req;
  logic                  slot_free;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic [DATA_WIDTH:0]   sum;

  assign res_valid_out = (state == ST_FULL);
  assign slot_free     = !res_valid_out || res_ready_in;
  assign busy_out      = res_valid_out || (|req_valid_in);

  // Reset gates the enable so nothing is acknowledged while state is being cleared.
  adder_rr_sched_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req     (req_valid_in),
    .ptr     (ptr),
    .en      (slot_free && !rst_in),
    .grant   (req_ready_out),
    .win     (win),
    .any_req (any_req)
  );

  assign xfer  = any_req && slot_free && !rst_in;
  assign a_sel = req_a_in[win*DATA_WIDTH +: DATA_WIDTH];
  assign b_sel = req_b_in[win*DATA_WIDTH +: DATA_WIDTH];

  adder #(
    .W (DATA_WIDTH + 1)
  ) u_add (
    .a   ({1'b0, a_sel}),
    .b   ({1'b0, b_sel}),
    .sum (sum)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= ST_EMPTY;
      res_data_out  <= '0;
      res_carry_out <= 1'b0;
      res_id_out    <= '0;
      ptr           <= ID_WIDTH'(RR_PTR_RESET);
    end else if (xfer) begin
      state                         <= ST_FULL;
      {res_carry_out, res_data_out} <= sum;
      res_id_out                    <= win;
      ptr <= (int'(win) == NUM_REQ - 1) ? ID_WIDTH'(RR_PTR_RESET) : win + ID_WIDTH'(1);
    end else if (res_ready_in) begin
      // Data/carry/id deliberately keep their last values once consumed.
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_adder_rr_sched.sv
// Randomised + directed bench for adder_rr_sched with a queue scoreboard.
// Inputs change on the falling edge; outputs are sampled shortly after.
module tb_adder_rr_sched;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int IW = 2;

  logic            clk_in;
  logic            rst_in;
  logic [N-1:0]    req_valid_in;
  logic [N*DW-1:0] req_a_in;
  logic [N*DW-1:0] req_b_in;
  logic [N-1:0]    req_ready_out;
  logic            res_valid_out;
  logic            res_ready_in;
  logic [DW-1:0]   res_data_out;
  logic            res_carry_out;
  logic [IW-1:0]   res_id_out;
  logic            busy_out;

  adder_rr_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_a_in      (req_a_in),
    .req_b_in      (req_b_in),
    .req_ready_out (req_ready_out),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_data_out  (res_data_out),
    .res_carry_out (res_carry_out),
    .res_id_out    (res_id_out),
    .busy_out      (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int d;
    int c;
    int id;
  } exp_t;

  exp_t   exp_q[$];
  int     errs;
  int     checks;

  // Requester-side state: a request stays posted until its handshake.
  logic [N-1:0] vld;
  logic [DW-1:0] a_op[N];
  logic [DW-1:0] b_op[N];

  // Reference model: occupancy and rotation pointer.
  bit mdl_full;
  int mdl_ptr;
  bit stall_prev;
  int prev_d, prev_c, prev_id;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic post(input int i, input int a, input int b);
    if (!vld[i]) begin
      vld[i]  = 1'b1;
      a_op[i] = DW'(a);
      b_op[i] = DW'(b);
    end
  endtask

  task automatic post_rand(input int i);
    post(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
  endtask

  // One cycle: drive, predict, compare, step past the rising edge.
  task automatic tick(input logic rdy);
    logic [N-1:0] got_rdy;
    logic [N-1:0] exp_rdy;
    bit   fnd;
    int   w;
    int   s;
    bit   slot;
    exp_t e;
    req_valid_in = vld;
    for (int i = 0; i < N; i++) begin
      req_a_in[i*DW +: DW] = a_op[i];
      req_b_in[i*DW +: DW] = b_op[i];
    end
    res_ready_in = rdy;
    #1;
    got_rdy = req_ready_out;
    chk("res_valid", 32'(res_valid_out), 32'(mdl_full));
    chk("busy", 32'(busy_out), 32'(mdl_full || (vld != '0)));
    if (stall_prev) begin
      chk("stall_data", 32'(res_data_out), 32'(prev_d));
      chk("stall_carry", 32'(res_carry_out), 32'(prev_c));
      chk("stall_id", 32'(res_id_out), 32'(prev_id));
    end
    slot = !mdl_full || rdy;
    fnd  = 1'b0;
    w    = 0;
    for (int k = 0; k < N; k++) begin
      if (!fnd && vld[(mdl_ptr + k) % N]) begin
        fnd = 1'b1;
        w   = (mdl_ptr + k) % N;
      end
    end
    exp_rdy = '0;
    if (fnd && slot) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(got_rdy), 32'(exp_rdy));
    stall_prev = mdl_full && !rdy;
    prev_d  = int'(res_data_out);
    prev_c  = int'(res_carry_out);
    prev_id = int'(res_id_out);
    if (fnd && slot) begin
      s    = int'(a_op[w]) + int'(b_op[w]);
      e.d  = s % 16;
      e.c  = (s >= 16) ? 1 : 0;
      e.id = w;
      exp_q.push_back(e);
      mdl_ptr  = (w + 1) % N;
      mdl_full = 1'b1;
    end else if (rdy) begin
      mdl_full = 1'b0;
    end
    @(posedge clk_in);
    vld = vld & ~(got_rdy & vld);
    @(negedge clk_in);
  endtask

  // Monitor: pops one expectation per consumed result.
  always begin
    exp_t e;
    @(negedge clk_in);
    #2;
    if (!rst_in && res_valid_out === 1'b1 && res_ready_in === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_result: got id=%0d data=%0h, expected none", res_id_out, res_data_out);
      end else begin
        e = exp_q.pop_front();
        chk("res_id", 32'(res_id_out), 32'(e.id));
        chk("res_data", 32'(res_data_out), 32'(e.d));
        chk("res_carry", 32'(res_carry_out), 32'(e.c));
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(res_valid_out), 32'd0);
    chk({tag, "_data"}, 32'(res_data_out), 32'd0);
    chk({tag, "_carry"}, 32'(res_carry_out), 32'd0);
    chk({tag, "_id"}, 32'(res_id_out), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready_out), 32'd0);
  endtask

  initial begin
    int guard;
    errs = 0;
    checks = 0;
    vld = '0;
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    mdl_full = 1'b0;
    mdl_ptr = 0;
    stall_prev = 1'b0;
    prev_d = 0;
    prev_c = 0;
    prev_id = 0;
    rst_in = 1'b1;
    req_valid_in = '1;
    req_a_in = '0;
    req_b_in = '0;
    res_ready_in = 1'b0;
    #2;
    check_zero("reset");
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Mid-stream asynchronous reset with a pending result.
    post(1, 5, 6);
    tick(1'b0);
    tick(1'b0);
    req_valid_in = '1;
    #1 rst_in = 1'b1;
    #1;
    check_zero("midrst");
    vld = '0;
    req_valid_in = '0;
    exp_q.delete();
    mdl_full = 1'b0;
    mdl_ptr = 0;
    stall_prev = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Lone requester 2 after reset: 3 + 4.
    post(2, 3, 4);
    tick(1'b1);
    tick(1'b1);

    // Fairness: everyone valid, consumer always ready.
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) post_rand(i);
      tick(1'b1);
    end
    tick(1'b1);

    // Overflow corner cases on requester 1.
    post(1, 15, 1); tick(1'b1);
    post(1, 8, 8);  tick(1'b1);
    post(1, 7, 8);  tick(1'b1);
    tick(1'b1);

    // Backpressure: stall 5 cycles with 0 and 3 waiting, then release.
    post(1, 9, 9);
    tick(1'b0);
    post(0, 1, 2);
    post(3, 4, 5);
    for (int c = 0; c < 5; c++) tick(1'b0);
    for (int c = 0; c < 3; c++) tick(1'b1);

    // Pointer hold across idle cycles.
    post(1, 2, 2);
    tick(1'b1);
    for (int c = 0; c < 10; c++) tick(1'b1);
    post(0, 10, 3);
    post(2, 11, 4);
    for (int c = 0; c < 3; c++) tick(1'b1);

    // Sparse pulses on requester 3 only.
    for (int c = 0; c < 12; c++) begin
      if (c % 3 == 0) post_rand(3);
      tick(1'b1);
    end

    // Random soak.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) post_rand(i);
      tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    // Drain.
    guard = 0;
    while ((exp_q.size() != 0 || vld != '0) && guard < 40) begin
      tick(1'b1);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0 || vld != '0) begin
      errs++;
      $display("FAIL drain: pending=%0d requests=%0h, expected none", exp_q.size(), vld);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
